rpn_stack_engine: RTL and testbench

//  Parametrised RPN evaluation core for the calculator: LIFO operand stack plus ALU driven by a

---
 rtl/rpn_stack_engine.sv | 268 ++++++++++++++++++++++++++
 tb/tb_rpn_stack_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_engine.sv
// ---------------------------------------------------------------------------
// rpn_stack_engine
//
// RPN evaluation core: a LIFO operand stack plus ALU, fed by a valid/ready
// command stream from the input decoder. The top of stack and the depth go
// straight to the display driver.
//
// Optional feature macro: RPN_MUL_EN
//   defined   -> opcode 4 (MUL) runs a shift-add multiply, one multiplier bit
//                per cycle, WIDTH cycles from accept to ready.
//   undefined -> no multiplier; opcode 4 is flagged as an illegal op.
//
// Ports
//   CLOCK_50   in   1      clock, rising edge
//   reset      in   1      asynchronous active-high reset, clears all state
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      engine can accept a command
//   cmd_op     in   3      0 PUSH,1 POP,2 ADD,3 SUB,4 MUL,5 DUP,6 SWAP,7 CLEAR
//   cmd_data   in   WIDTH  PUSH operand
//   top        out  WIDTH  top of stack, 0 when empty
//   depth      out  DW     number of valid entries
//   busy       out  1      multiply in progress
//   err        out  1      sticky error flag
//   err_code   out  2      00 none, 01 overflow, 10 underflow, 11 illegal op
// ---------------------------------------------------------------------------
module rpn_stack_engine #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] top,
    output logic [DW-1:0]    depth,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);
    localparam logic [DW-1:0] DEPTH_TWO  = DW'(2);

    localparam logic [2:0] OP_PUSH  = 3'd0;
    localparam logic [2:0] OP_POP   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_DUP   = 3'd5;
    localparam logic [2:0] OP_SWAP  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t           state_reg, state_next;
    logic [DW-1:0]    depth_reg, depth_next;
    logic             err_reg, err_next;
    logic [1:0]       err_code_reg, err_code_next;

`ifdef RPN_MUL_EN
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] mul_a_reg, mul_a_next;   // multiplicand, shifted left
    logic [WIDTH-1:0] mul_b_reg, mul_b_next;   // multiplier, shifted right
    logic [WIDTH-1:0] acc_reg, acc_next;       // partial product, low bits only
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] acc_sum;
`endif

    // Stack storage: up to two writes per cycle (SWAP needs both).
    logic [WIDTH-1:0] stack_mem [0:DEPTH-1];
    logic             wr0_en, wr1_en;
    logic [AW-1:0]    wr0_idx, wr1_idx;
    logic [WIDTH-1:0] wr0_data, wr1_data;

    logic [AW-1:0]    top_idx, sec_idx, push_idx;
    logic [WIDTH-1:0] top_val, sec_val;
    logic             accept;
    logic             is_empty, is_full, lt_two;

    assign top_idx  = AW'(depth_reg - DEPTH_ONE);
    assign sec_idx  = AW'(depth_reg - DEPTH_TWO);
    assign push_idx = AW'(depth_reg);
    assign top_val  = stack_mem[top_idx];
    assign sec_val  = stack_mem[sec_idx];

    assign is_empty = (depth_reg == '0);
    assign is_full  = (depth_reg == DEPTH_FULL);
    assign lt_two   = (depth_reg < DEPTH_TWO);

    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign top      = is_empty ? '0 : top_val;
    assign depth    = depth_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;

`ifdef RPN_MUL_EN
    assign busy    = (state_reg == ST_MUL);
    assign acc_sum = acc_reg + (mul_b_reg[0] ? mul_a_reg : '0);
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        depth_next    = depth_reg;
        err_next      = err_reg;
        err_code_next = err_code_reg;
        wr0_en        = 1'b0;
        wr0_idx       = '0;
        wr0_data      = '0;
        wr1_en        = 1'b0;
        wr1_idx       = '0;
        wr1_data      = '0;
`ifdef RPN_MUL_EN
        mul_a_next    = mul_a_reg;
        mul_b_next    = mul_b_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_CLEAR) begin
                        depth_next    = '0;
                        err_next      = 1'b0;
                        err_code_next = 2'b00;
                    end else if (!err_reg) begin
                        // Only reachable with err clear, so the first error
                        // recorded is never overwritten.
                        case (cmd_op)
                            OP_PUSH: begin
                                if (is_full) begin
                                    err_next = 1'b1; err_code_next = ERR_OVF;
                                end else begin
                                    wr0_en = 1'b1; wr0_idx = push_idx; wr0_data = cmd_data;
                                    depth_next = depth_reg + DEPTH_ONE;
                                end
                            end
                            OP_POP: begin
                                if (is_empty) begin
                                    err_next = 1'b1; err_code_next = ERR_UNF;
                                end else begin
                                    depth_next = depth_reg - DEPTH_ONE;
                                end
                            end
                            OP_ADD, OP_SUB: begin
                                if (lt_two) begin
                                    err_next = 1'b1; err_code_next = ERR_UNF;
                                end else begin
                                    wr0_en   = 1'b1;
                                    wr0_idx  = sec_idx;
                                    wr0_data = (cmd_op == OP_ADD) ? (sec_val + top_val)
                                                                  : (sec_val - top_val);
                                    depth_next = depth_reg - DEPTH_ONE;
                                end
                            end
                            OP_MUL: begin
`ifdef RPN_MUL_EN
                                if (lt_two) begin
                                    err_next = 1'b1; err_code_next = ERR_UNF;
                                end else begin
                                    state_next = ST_MUL;
                                    mul_a_next = sec_val;
                                    mul_b_next = top_val;
                                    acc_next   = '0;
                                    cnt_next   = '0;
                                end
`else
                                err_next = 1'b1; err_code_next = ERR_ILL;
`endif
                            end
                            OP_DUP: begin
                                if (is_empty) begin
                                    err_next = 1'b1; err_code_next = ERR_UNF;
                                end else if (is_full) begin
                                    err_next = 1'b1; err_code_next = ERR_OVF;
                                end else begin
                                    wr0_en = 1'b1; wr0_idx = push_idx; wr0_data = top_val;
                                    depth_next = depth_reg + DEPTH_ONE;
                                end
                            end
                            OP_SWAP: begin
                                if (lt_two) begin
                                    err_next = 1'b1; err_code_next = ERR_UNF;
                                end else begin
                                    wr0_en = 1'b1; wr0_idx = top_idx; wr0_data = sec_val;
                                    wr1_en = 1'b1; wr1_idx = sec_idx; wr1_data = top_val;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_MUL: begin
`ifdef RPN_MUL_EN
                mul_a_next = mul_a_reg << 1;
                mul_b_next = mul_b_reg >> 1;
                acc_next   = acc_sum;
                cnt_next   = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    // Last multiplier bit: result replaces both operands.
                    wr0_en     = 1'b1;
                    wr0_idx    = sec_idx;
                    wr0_data   = acc_sum;
                    depth_next = depth_reg - DEPTH_ONE;
                    state_next = ST_IDLE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            depth_reg    <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= 2'b00;
`ifdef RPN_MUL_EN
            mul_a_reg    <= '0;
            mul_b_reg    <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            depth_reg    <= depth_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
`ifdef RPN_MUL_EN
            mul_a_reg    <= mul_a_next;
            mul_b_reg    <= mul_b_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
`endif
        end
    end

    // Entries above depth are don't-care, so storage needs no reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLOCK_50) begin
                if (wr0_en && (wr0_idx == AW'(gi))) begin
                    stack_mem[gi] <= wr0_data;
                end else if (wr1_en && (wr1_idx == AW'(gi))) begin
                    stack_mem[gi] <= wr1_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rpn_stack_engine.sv
// ---------------------------------------------------------------------------
// tb_rpn_stack_engine
//
// Directed scenarios plus random command stream for rpn_stack_engine
// (WIDTH=16, DEPTH=8). Expected values come from a queue-based stack model.
// Works with or without RPN_MUL_EN defined.
// ---------------------------------------------------------------------------
module tb_rpn_stack_engine;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);
    localparam longint MASK = (64'd1 << WIDTH) - 1;
`ifdef RPN_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [WIDTH-1:0] top;
    logic [DW-1:0]    depth;
    logic             busy;
    logic             err;
    logic [1:0]       err_code;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    longint   st[$];
    bit       m_err  = 1'b0;
    bit [1:0] m_code = 2'b00;

    rpn_stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .top       (top),
        .depth     (depth),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input bit [1:0] c);
        m_err  = 1'b1;
        m_code = c;
    endtask

    // Applies one command to the model; lat = accept-to-ready latency.
    task automatic model_apply(input logic [2:0] op, input logic [WIDTH-1:0] d, output int lat);
        longint a, b;
        lat = 0;
        if (op == 3'd7) begin
            st.delete(); m_err = 1'b0; m_code = 2'b00;
        end else if (!m_err) begin
            case (op)
                3'd0: if (st.size() == DEPTH) raise(2'b01); else st.push_back(longint'(d));
                3'd1: if (st.size() == 0) raise(2'b10); else void'(st.pop_back());
                3'd2, 3'd3, 3'd4: begin
                    if (op == 3'd4 && !MUL_EN) raise(2'b11);
                    else if (st.size() < 2) raise(2'b10);
                    else begin
                        b = st.pop_back();
                        a = st.pop_back();
                        if (op == 3'd2)      st.push_back((a + b) & MASK);
                        else if (op == 3'd3) st.push_back((a - b) & MASK);
                        else begin
                            st.push_back((a * b) & MASK);
                            lat = WIDTH;
                        end
                    end
                end
                3'd5: begin
                    if (st.size() == 0) raise(2'b10);
                    else if (st.size() == DEPTH) raise(2'b01);
                    else st.push_back(st[st.size()-1]);
                end
                3'd6: begin
                    if (st.size() < 2) raise(2'b10);
                    else begin
                        b = st.pop_back();
                        a = st.pop_back();
                        st.push_back(b);
                        st.push_back(a);
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_top();
        return (st.size() == 0) ? 32'd0 : 32'(st[st.size()-1]);
    endfunction

    task automatic check_state(input string tag);
        check({tag, " top"},      32'(top),      exp_top());
        check({tag, " depth"},    32'(depth),    32'(st.size()));
        check({tag, " err"},      32'(err),      32'(m_err));
        check({tag, " err_code"}, 32'(err_code), 32'(m_code));
        check({tag, " busy"},     32'(busy),     32'd0);
        check({tag, " ready"},    32'(cmd_ready), 32'd1);
    endtask

    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] d, input string tag);
        int lat;
        int n;
        logic [31:0] pre_top;
        logic [31:0] pre_depth;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        pre_top   = 32'(top);
        pre_depth = 32'(depth);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = WIDTH'($urandom);
        model_apply(op, d, lat);
        if (lat > 0) begin
            check({tag, " mul ready low"}, 32'(cmd_ready), 32'd0);
            check({tag, " mul busy"},      32'(busy),      32'd1);
            check({tag, " mul top held"},  32'(top),       pre_top);
            check({tag, " mul depth held"}, 32'(depth),    pre_depth);
        end
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        $display("cmd op=%0d data=%04h -> top=%04h depth=%0d err=%0b code=%02b lat=%0d",
                 op, d, top, depth, err, err_code, n);
        check_state(tag);
    endtask

    initial begin
        logic [2:0] rop;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: 5 - 3
        send(3'd0, 16'd5, "t1 push5");
        send(3'd0, 16'd3, "t1 push3");
        send(3'd3, 16'd0, "t1 sub");
        send(3'd7, 16'd0, "t1 clear");

        // 2: wrap add, dup, swap
        send(3'd0, 16'hFFFF, "t2 push");
        send(3'd0, 16'h0002, "t2 push");
        send(3'd2, 16'd0,    "t2 add");
        send(3'd5, 16'd0,    "t2 dup");
        send(3'd0, 16'd7,    "t2 push7");
        send(3'd6, 16'd0,    "t2 swap");
        send(3'd7, 16'd0,    "t2 clear");

        // 3: overflow at full stack, sticky error, clear
        for (int i = 1; i <= 9; i++) send(3'd0, 16'(i), "t3 push");
        send(3'd0, 16'd10, "t3 push ignored");
        send(3'd5, 16'd0,  "t3 dup ignored");
        send(3'd7, 16'd0,  "t3 clear");

        // 4: underflow from empty, discarded commands while in error
        send(3'd2, 16'd0,  "t4 add");
        send(3'd1, 16'd0,  "t4 pop ignored");
        send(3'd0, 16'd42, "t4 push ignored");
        send(3'd7, 16'd0,  "t4 clear");
        send(3'd1, 16'd0,  "t4 pop empty");
        send(3'd7, 16'd0,  "t4 clear2");

        // 5: 300 * 300
        send(3'd0, 16'd300, "t5 push");
        send(3'd0, 16'd300, "t5 push");
        send(3'd4, 16'd0,   "t5 mul");
        send(3'd7, 16'd0,   "t5 clear");

        // Random command stream
        for (int i = 0; i < 400; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd7 && $urandom_range(0, 1) == 0) rop = 3'd0;
            if (m_err && $urandom_range(0, 3) == 0) rop = 3'd7;
            send(rop, WIDTH'($urandom), "rand");
        end

        // 6: asynchronous reset in the middle of a multiply
        send(3'd7, 16'd0,   "t6 clear");
        send(3'd0, 16'd300, "t6 push");
        send(3'd0, 16'd300, "t6 push");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_data  = '0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        st.delete();
        m_err  = 1'b0;
        m_code = 2'b00;
        $display("reset mid-mul -> top=%04h depth=%0d busy=%0b ready=%0b err=%0b",
                 top, depth, busy, cmd_ready, err);
        check_state("t6 reset");
        @(negedge clk);
        rst = 1'b0;
        send(3'd0, 16'h1234, "t6 push after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
